// File: rtl/descarregador_pkg.sv
// Types shared by the elevator cargo RAM, its loader and the unload controller.
package descarregador_pkg;

   typedef logic [1:0] andar_t;
   typedef logic [1:0] tipo_t;
   typedef logic [2:0] estado_t;

   localparam tipo_t TIPO_VAZIO = 2'b00;

   localparam estado_t OCIOSO   = 3'd0;
   localparam estado_t ENDERECA = 3'd1;
   localparam estado_t COMPARA  = 3'd2;
   localparam estado_t ENTREGA  = 3'd3;
   localparam estado_t REMOVE   = 3'd4;
   localparam estado_t FIM      = 3'd5;

   function automatic logic entrega_aqui(input tipo_t tipo, input andar_t destino, input andar_t andar);
      return (tipo != TIPO_VAZIO) && (destino == andar);
   endfunction

endpackage

// File: rtl/descarregador_elevador.sv
// Cargo RAM unload controller: scans every slot and hands the objects for the current floor
// to the floor logic. Optional handshake timeout enabled by defining DESCARREGADOR_TIMEOUT_EN.
module descarregador_elevador
   import descarregador_pkg::*;
#(
   parameter int N_SLOTS = 8,
   parameter int ADDR_W  = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                           clk,
   input  logic                           clear,
   input  logic                           inicia,
   input  logic [1:0]                     andar_atual,
   output logic [ADDR_W-1:0]              addr,
   input  logic [1:0]                     tipo_objeto,
   input  logic [1:0]                     destino_objeto,
   output logic                           obj_valid,
   output logic [1:0]                     obj_tipo,
   input  logic                           obj_ready,
   output logic                           tira_objetos,
   output logic                           ocupado,
   output logic                           pronto,
   output logic [$clog2(N_SLOTS+1)-1:0]   contagem,
   output logic                           erro
);

   localparam int CNT_W = $clog2(N_SLOTS + 1);
   localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(N_SLOTS - 1);

   estado_t             state_r, state_s;
   logic [ADDR_W-1:0]   idx_r, idx_s, addr_r;
   andar_t              andar_r;
   tipo_t               obj_tipo_r;
   logic [CNT_W-1:0]    contagem_r;
   logic                obj_valid_r, tira_r, pronto_r, ocupado_r;
   logic                timeout_s;
   logic                ultimo_s;
   logic                aceita_s;

   assign ultimo_s = (idx_r == ULTIMO);
   assign aceita_s = (state_r == OCIOSO) && inicia;

   // Next state and scan index
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      case (state_r)
         OCIOSO: begin
            if (inicia) begin
               state_s = ENDERECA;
               idx_s   = {ADDR_W{1'b0}};
            end else begin
               state_s = OCIOSO;
            end
         end
         ENDERECA: state_s = COMPARA;
         COMPARA: begin
            if (entrega_aqui(tipo_objeto, destino_objeto, andar_r)) begin
               state_s = ENTREGA;
            end else if (ultimo_s) begin
               state_s = (contagem_r != {CNT_W{1'b0}}) ? REMOVE : FIM;
            end else begin
               idx_s   = idx_r + ADDR_W'(1);
               state_s = ENDERECA;
            end
         end
         ENTREGA: begin
            if (timeout_s) begin
               state_s = FIM;
            end else if (obj_ready) begin
               if (ultimo_s) begin
                  state_s = REMOVE;
               end else begin
                  idx_s   = idx_r + ADDR_W'(1);
                  state_s = ENDERECA;
               end
            end else begin
               state_s = ENTREGA;
            end
         end
         REMOVE:  state_s = FIM;
         FIM:     state_s = OCIOSO;
         default: state_s = OCIOSO;
      endcase
   end

   // State, latched stop data and outputs registered from the next state
   always_ff @(posedge clk) begin
      if (clear) begin
         state_r     <= OCIOSO;
         idx_r       <= {ADDR_W{1'b0}};
         addr_r      <= {ADDR_W{1'b0}};
         andar_r     <= 2'b00;
         obj_tipo_r  <= TIPO_VAZIO;
         contagem_r  <= {CNT_W{1'b0}};
         obj_valid_r <= 1'b0;
         tira_r      <= 1'b0;
         pronto_r    <= 1'b0;
         ocupado_r   <= 1'b0;
      end else begin
         state_r     <= state_s;
         idx_r       <= idx_s;
         addr_r      <= (state_s == OCIOSO) ? {ADDR_W{1'b0}} : idx_s;
         obj_valid_r <= (state_s == ENTREGA);
         tira_r      <= (state_s == REMOVE);
         pronto_r    <= (state_s == FIM);
         ocupado_r   <= (state_s != OCIOSO);
         if (aceita_s) begin
            andar_r <= andar_atual;
         end
         if ((state_r == COMPARA) && (state_s == ENTREGA)) begin
            obj_tipo_r <= tipo_objeto;
         end
         if (aceita_s) begin
            contagem_r <= {CNT_W{1'b0}};
         end else if ((state_r == ENTREGA) && obj_ready) begin
            contagem_r <= contagem_r + CNT_W'(1);
         end
      end
   end

`ifdef DESCARREGADOR_TIMEOUT_EN
   localparam int ESPERA_W = $clog2(TIMEOUT + 1);

   logic [ESPERA_W-1:0] espera_r;
   logic                erro_r;

   assign timeout_s = (state_r == ENTREGA) && !obj_ready && (espera_r == ESPERA_W'(TIMEOUT - 1));

   // Cycles spent in the current ENTREGA, and the sticky timeout flag
   always_ff @(posedge clk) begin
      if (clear) begin
         espera_r <= {ESPERA_W{1'b0}};
         erro_r   <= 1'b0;
      end else begin
         espera_r <= (state_r == ENTREGA) ? espera_r + ESPERA_W'(1) : {ESPERA_W{1'b0}};
         if (aceita_s) begin
            erro_r <= 1'b0;
         end else if (timeout_s) begin
            erro_r <= 1'b1;
         end
      end
   end

   assign erro = erro_r;
`else
   assign timeout_s = 1'b0;
   assign erro      = 1'b0;
`endif

   assign addr         = addr_r;
   assign obj_valid    = obj_valid_r;
   assign obj_tipo     = obj_tipo_r;
   assign tira_objetos = tira_r;
   assign ocupado      = ocupado_r;
   assign pronto       = pronto_r;
   assign contagem     = contagem_r;

endmodule

// File: tb/tb_descarregador_elevador.sv
// Bench for descarregador_elevador: table vectors, corner-case sequences and random unloads
// checked against a slot-by-slot cycle-cost model.
module tb_descarregador_elevador;

   localparam int N_SLOTS = 8;
   localparam int TIMEOUT = 15;
`ifdef DESCARREGADOR_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   typedef struct {
      logic [31:0] ram;        // slot i = {tipo, destino} at nibble i
      logic [1:0]  andar;
      logic [31:0] waits;      // ready-low cycles for match j at nibble j
      int          restart_at; // observation index of a stray inicia, -1 = none
      int          exp_cont;
      int          exp_pronto; // cycle number, inicia cycle = 0
      int          exp_tira;   // -1 = no pulse
      int          exp_erro;
   } vec_t;

   logic        clk = 1'b0;
   logic        clear, inicia, obj_ready;
   logic [1:0]  andar_atual, tipo_objeto, destino_objeto, obj_tipo;
   logic [3:0]  addr, contagem;
   logic        obj_valid, tira_objetos, ocupado, pronto, erro;
   logic [31:0] ram_img;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   assign tipo_objeto    = (addr < 4'd8) ? ram_img[{addr[2:0], 2'b11} -: 2] : 2'b00;
   assign destino_objeto = (addr < 4'd8) ? ram_img[{addr[2:0], 2'b01} -: 2] : 2'b00;

   descarregador_elevador dut (
      .clk(clk), .clear(clear), .inicia(inicia), .andar_atual(andar_atual), .addr(addr),
      .tipo_objeto(tipo_objeto), .destino_objeto(destino_objeto), .obj_valid(obj_valid),
      .obj_tipo(obj_tipo), .obj_ready(obj_ready), .tira_objetos(tira_objetos),
      .ocupado(ocupado), .pronto(pronto), .contagem(contagem), .erro(erro)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, " addr"}, addr, 0);
      chk({nm, " obj_valid"}, obj_valid, 0);
      chk({nm, " obj_tipo"}, obj_tipo, 0);
      chk({nm, " tira"}, tira_objetos, 0);
      chk({nm, " pronto"}, pronto, 0);
      chk({nm, " ocupado"}, ocupado, 0);
      chk({nm, " contagem"}, contagem, 0);
      chk({nm, " erro"}, erro, 0);
   endtask

   // Each slot costs 2 cycles, a delivery 1 + its wait, removal 1, end 1.
   task automatic model(input logic [31:0] ram, input logic [1:0] andar, input logic [31:0] waits,
                        output int k, output int pronto_c, output int tira_c, output int erro_e,
                        output logic [15:0] tipos);
      int t, w;
      bit to;
      logic [1:0] tp, ds;
      t = 1; k = 0; to = 1'b0; tipos = 16'h0000;
      for (int s = 0; s < N_SLOTS; s++) begin
         if (!to) begin
            tp = ram[4*s+3 -: 2];
            ds = ram[4*s+1 -: 2];
            t += 2;
            if (tp != 2'b00 && ds == andar) begin
               w = int'(waits[4*k +: 4]);
               if (TIMEOUT_EN && w >= TIMEOUT) begin
                  t += TIMEOUT;
                  to = 1'b1;
               end else begin
                  tipos[2*k +: 2] = tp;
                  k++;
                  t += 1 + w;
               end
            end
         end
      end
      if (!to && k > 0) begin
         tira_c = t;
         t++;
      end else begin
         tira_c = -1;
      end
      pronto_c = t;
      erro_e = to ? 1 : 0;
   endtask

   task automatic run_unload(input vec_t v, input string nm);
      int k, ep, et, ee, e, hs, waited, w, pr_e, pr_n, tr_e, tr_n;
      logic [15:0] tipos;
      bit done, pv, pr;
      logic [1:0] pt;
      model(v.ram, v.andar, v.waits, k, ep, et, ee, tipos);
      ram_img = v.ram;
      andar_atual = v.andar;
      inicia = 1'b1;
      @(posedge clk); #1;
      inicia = 1'b0;
      andar_atual = 2'($urandom_range(0, 3));
      chk({nm, " ocupado start"}, ocupado, 1);
      chk({nm, " erro start"}, erro, 0);
      hs = 0; waited = 0; pr_e = -1; pr_n = 0; tr_e = -1; tr_n = 0;
      done = 1'b0; pv = 1'b0; pr = 1'b0; pt = 2'b00; e = 0;
      while (!done && e < 400) begin
         if (pv && pr) hs++;
         chk({nm, " contagem"}, contagem, hs);
         if (pv && !pr && !(TIMEOUT_EN && waited >= TIMEOUT)) begin
            chk({nm, " valid held"}, obj_valid, 1);
            chk({nm, " tipo held"}, obj_tipo, pt);
         end
         if (tira_objetos) begin tr_n++; tr_e = e; end
         if (pronto) begin pr_n++; pr_e = e; end
         if (pr_n > 0 && e > pr_e) done = 1'b1;
         inicia = (e == v.restart_at);
         if (e == v.restart_at) andar_atual = 2'd3;
         if (obj_valid) begin
            w = int'(v.waits[4*hs +: 4]);
            if (waited < w) begin
               obj_ready = 1'b0;
               waited++;
            end else begin
               obj_ready = 1'b1;
               chk({nm, " obj_tipo"}, obj_tipo, tipos[2*hs +: 2]);
            end
         end else begin
            obj_ready = 1'($urandom_range(0, 1));
            waited = 0;
         end
         pv = obj_valid; pr = obj_ready; pt = obj_tipo;
         if (!done) begin
            @(posedge clk); #1;
            e++;
         end
      end
      chk({nm, " finished in bound"}, done, 1);
      chk({nm, " pronto cycle"}, pr_e + 1, v.exp_pronto);
      chk({nm, " pronto pulses"}, pr_n, 1);
      chk({nm, " tira pulses"}, tr_n, (v.exp_tira >= 0) ? 1 : 0);
      chk({nm, " tira cycle"}, (tr_e < 0) ? -1 : tr_e + 1, v.exp_tira);
      chk({nm, " contagem end"}, contagem, v.exp_cont);
      chk({nm, " deliveries"}, hs, k);
      chk({nm, " erro end"}, erro, v.exp_erro);
      chk({nm, " ocupado idle"}, ocupado, 0);
      chk({nm, " addr idle"}, addr, 0);
      inicia = 1'b0;
      obj_ready = 1'b0;
   endtask

   initial begin
      vec_t tab[6];
      vec_t v;
      int k, ep, et, ee, n;
      logic [15:0] tipos;

      clear = 1'b1; inicia = 1'b0; andar_atual = 2'd0; obj_ready = 1'b0; ram_img = 32'h0;
      tab[0] = '{32'h0000A060, 2'd2, 32'h00000000, -1, 2, 20, 19, 0};
      tab[1] = '{32'h00000D02, 2'd2, 32'h00000000, -1, 0, 17, -1, 0};
      tab[2] = '{32'h0000A060, 2'd2, 32'h00000005, -1, 2, 25, 24, 0};
      tab[3] = '{32'h00F0A060, 2'd2, 32'h00000000,  5, 2, 20, 19, 0};
      tab[4] = '{32'h4C84C84C, 2'd0, 32'h00000000, -1, 8, 26, 25, 0};
      tab[5] = '{32'hD0000000, 2'd1, 32'h00000003, -1, 1, 22, 21, 0};

      repeat (3) @(posedge clk);
      #1;
      chk_reset("reset");
      clear = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) run_unload(tab[i], $sformatf("vec%0d", i));

      // clear held for two cycles while an object is being offered
      ram_img = 32'h0000A060; andar_atual = 2'd2; obj_ready = 1'b0; inicia = 1'b1;
      @(posedge clk); #1;
      inicia = 1'b0;
      n = 0;
      while (!obj_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("midclear reached ENTREGA", obj_valid, 1);
      clear = 1'b1;
      @(posedge clk); #1;
      chk_reset("midclear edge1");
      @(posedge clk); #1;
      chk_reset("midclear edge2");
      clear = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("postclear tira", tira_objetos, 0);
         chk("postclear pronto", pronto, 0);
         chk("postclear ocupado", ocupado, 0);
      end
      run_unload(tab[0], "after clear");

      // clear and inicia together
      clear = 1'b1; inicia = 1'b1;
      @(posedge clk); #1;
      chk("clear beats inicia", ocupado, 0);
      clear = 1'b0; inicia = 1'b0;
      @(posedge clk); #1;
      chk("clear beats inicia later", ocupado, 0);

`ifdef DESCARREGADOR_TIMEOUT_EN
      v = '{32'h0000A060, 2'd2, 32'h0000000F, -1, 0, 20, -1, 1};
      run_unload(v, "timeout");
      run_unload(tab[0], "after timeout");
`endif

      for (int r = 0; r < 25; r++) begin
         v.ram = $urandom;
         v.andar = 2'($urandom_range(0, 3));
         v.waits = 32'h0;
         for (int j = 0; j < 8; j++) v.waits[4*j +: 4] = 4'($urandom_range(0, 4));
         v.restart_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 14)) : -1;
         model(v.ram, v.andar, v.waits, k, ep, et, ee, tipos);
         v.exp_cont = k; v.exp_pronto = ep; v.exp_tira = et; v.exp_erro = ee;
         run_unload(v, $sformatf("rand%0d", r));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
